serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing d = a − b − b_in over WIDTH cycles, LSB first, through a single one-bit full-subtractor cell and a borrow flip-flop. It is the inverse-direction counterpart of the ripple full-adder datapath. It serves area-constrained accumulate/compare paths in the digit-detection datapath, such as distance and threshold differences, where one result per WIDTH+1 cycles is sufficient. A start/done handshake frames each operation.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  request; sampled only while busy = 0
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- b_in  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while the operation is in RUN
- done  output  1  one-cycle pulse when d and b_out become valid
- d  output  WIDTH  difference; held until the next completion
- b_out  output  1  borrow-out; 1 when a < b + b_in

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE with start = 1:
  - load shift registers sa ← a and sb ← b
  - borrow ← b_in
  - count ← 0
  - go to RUN
- IDLE with start = 0: stay in IDLE.
- DONE with start = 0: go to IDLE.
- Each RUN edge processes one bit:
  - diff = sa[0] ^ sb[0] ^ borrow
  - borrow ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)
  - sa and sb shift right by one
  - diff shifts into the MSB of the result register
  - count increments
- When count reaches WIDTH−1, the RUN edge also latches the final result into d and b_out, asserts done, and moves to DONE.
- Arithmetic is unsigned modulo 2^WIDTH. b_out is the final borrow.
- start while busy = 1 is ignored; the operands in flight are unaffected.
- Operand inputs are don't-care except on the accepted start edge.
- d and b_out change only on the completion edge or on reset.

## Timing
- Reset values: busy = 0, done = 0, d = 0, b_out = 0, borrow = 0, count = 0, state = IDLE.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.
- Call the accepted start edge E0:
  - busy is high in the cycles after E0 through edge E0+WIDTH
  - done is high for exactly the one cycle after edge E0+WIDTH
  - latency is WIDTH+1 cycles from start sampled to done observed
- Back-to-back: start high in the DONE cycle is accepted with no idle cycle. Throughput is one result per WIDTH+1 cycles.
- busy = 0 in the DONE cycle, so start is accepted there.

## Configuration
- SERIAL_SUB_SAT_EN defined: unsigned saturation. When the final borrow is 1, d is forced to 0 at completion; b_out still reports 1.
- SERIAL_SUB_SAT_EN undefined: d wraps modulo 2^WIDTH.
- Timing and handshake are identical in both builds.

## Structure
- Package serial_sub_pkg contains:
  - state typedef enum {IDLE, RUN, DONE}
  - counter width constant, $clog2(WIDTH)
- Sub-module full_subtractor: combinational one-bit cell.
  - inputs a, b, b_in; outputs d, b_out
  - implemented with gate primitives, matching the full-adder cell style
  - instantiated once in the serial datapath
- Top level contains the FSM, shift registers, borrow flop, counter and output registers.

## Test plan
- WIDTH = 8, a = 0x5A, b = 0x21, b_in = 0 → d = 0x39, b_out = 0. done is high exactly 9 cycles after start is sampled and lasts one cycle.
- a = 0x10, b = 0x20, b_in = 0 → b_out = 1; d = 0xF0 without the macro, d = 0x00 with SERIAL_SUB_SAT_EN.
- a = 0x00, b = 0x00, b_in = 1 → d = 0xFF, b_out = 1 (0x00 with SERIAL_SUB_SAT_EN). Also a = 0xFF, b = 0xFF, b_in = 0 → d = 0x00, b_out = 0.
- Start a = 0x80, b = 0x01, then hold start high with a = 0x00, b = 0xFF during RUN → the first result, d = 0x7F, b_out = 0, is unaffected. A second operation is accepted in the DONE cycle and its done appears 9 cycles later.
- Assert rst_n low at RUN cycle 4 → all outputs are 0 and state is IDLE with no done pulse. A following start with a = 0x09, b = 0x03 completes with d = 0x06.
- Random sweep with WIDTH = 8 and WIDTH = 13 against the reference model (a − b − b_in) mod 2^WIDTH and its borrow. Check that d and b_out stay stable between done pulses.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and counter sizing for serial_subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit a - b - b_in cell built from gate primitives
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);
  logic w_x, w_na, w_nx, w_g0, w_g1;
  xor u_x0 (w_x, a, b);
  xor u_x1 (d, w_x, b_in);
  not u_n0 (w_na, a);
  not u_n1 (w_nx, w_x);
  and u_a0 (w_g0, w_na, b);
  and u_a1 (w_g1, w_nx, b_in);
  or  u_o0 (b_out, w_g0, w_g1);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial d = a - b - b_in, LSB first, one result per WIDTH+1 cycles.
// Define SERIAL_SUB_SAT_EN to clamp underflowing results to zero.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_d, w_shift, w_final;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow, r_bout, w_diff, w_bnext, w_load, w_last;

  full_subtractor u_fs (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .b_in (r_borrow),
    .d    (w_diff),
    .b_out(w_bnext)
  );

  assign w_load  = start && r_state != RUN;
  assign w_last  = r_state == RUN && r_cnt == CW'(WIDTH - 1);
  assign w_shift = {w_diff, r_res};
`ifdef SERIAL_SUB_SAT_EN
  assign w_final = w_bnext ? '0 : w_shift;
`else
  assign w_final = w_shift;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
  end

  always_comb begin
    busy = r_state == RUN;
    done = r_state == DONE;
  end

  // result bits enter at the top so the LSB-first stream lands in place after WIDTH shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else if (w_load) begin
      r_sa     <= a;
      r_sb     <= b;
      r_borrow <= b_in;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_sa     <= r_sa >> 1;
      r_sb     <= r_sb >> 1;
      r_res    <= w_shift[WIDTH-1:1];
      r_borrow <= w_bnext;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_d    <= w_final;
        r_bout <= w_bnext;
      end
    end
  end

  assign d     = r_d;
  assign b_out = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of WIDTH=8 and WIDTH=13 instances against an arithmetic model
module tb_serial_subtractor;
  logic        clk = 0, rst_n = 0, st = 0, sel = 0, bi = 0;
  logic [15:0] av = 0, bv = 0;
  logic        busy8, done8, bo8, busy13, done13, bo13;
  logic [7:0]  d8;
  logic [12:0] d13;
  logic        busy_s, done_s, bo_s;
  logic [15:0] d_s;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st & ~sel), .a(av[7:0]), .b(bv[7:0]), .b_in(bi),
    .busy(busy8), .done(done8), .d(d8), .b_out(bo8)
  );
  serial_subtractor #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .start(st & sel), .a(av[12:0]), .b(bv[12:0]), .b_in(bi),
    .busy(busy13), .done(done13), .d(d13), .b_out(bo13)
  );

  assign busy_s = sel ? busy13 : busy8;
  assign done_s = sel ? done13 : done8;
  assign bo_s   = sel ? bo13 : bo8;
  assign d_s    = sel ? {3'b0, d13} : {8'b0, d8};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_sub(input int w, input logic [15:0] x, input logic [15:0] y, input logic c);
    int diff;
    logic bor;
    logic [15:0] dm;
    diff = int'(x) - int'(y) - int'(c);
    bor  = diff < 0;
    dm   = 16'((diff + (1 << w)) % (1 << w));
`ifdef SERIAL_SUB_SAT_EN
    if (bor) dm = 16'h0;
`endif
    return {bor, dm};
  endfunction

  // Entered at a negedge; returns at the negedge of the DONE cycle when hold is set, else one cycle later.
  task automatic op(input logic s, input logic [15:0] x, input logic [15:0] y, input logic c,
                    input logic hold, input string tag);
    int w;
    logic [15:0] m;
    logic [16:0] e;
    w = s ? 13 : 8;
    m = 16'((1 << w) - 1);
    sel = s; av = x & m; bv = y & m; bi = c; st = 1;
    e = ref_sub(w, av, bv, c);
    for (int n = 1; n <= w + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        st = hold;
        if (hold) begin av = 0; bv = m; bi = ~c; end
      end
      if (n <= w) begin
        chk({tag, "_busy"}, 16'(busy_s), 16'h1);
        if (n == 1 || n == w) chk({tag, "_early"}, 16'(done_s), 16'h0);
      end else begin
        chk({tag, "_done"}, 16'(done_s), 16'h1);
        chk({tag, "_busyd"}, 16'(busy_s), 16'h0);
        chk({tag, "_d"}, d_s, e[15:0]);
        chk({tag, "_bout"}, 16'(bo_s), 16'(e[16]));
      end
    end
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_pulse"}, 16'(done_s), 16'h0);
    end
  endtask

  logic [7:0]  p8;
  logic [12:0] p13;
  logic        pb8, pb13, pv = 0;
  always @(negedge clk) begin
    if (rst_n && pv) begin
      if (!done8)  chk("stable8", {7'b0, bo8, d8}, {7'b0, pb8, p8});
      if (!done13) chk("stable13", {2'b0, bo13, d13}, {2'b0, pb13, p13});
    end
    p8 <= d8; pb8 <= bo8; p13 <= d13; pb13 <= bo13; pv <= rst_n;
  end

  initial begin
    logic s, c, h;
    logic [15:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy8), 16'h0);
    chk("rst_done", 16'(done8), 16'h0);
    chk("rst_d", {8'b0, d8}, 16'h0);
    chk("rst_bout", {15'b0, bo8}, 16'h0);
    chk("rst_d13", {3'b0, d13}, 16'h0);
    #2 rst_n = 1;
    @(negedge clk);
    op(0, 16'h5A, 16'h21, 0, 0, "basic");
    op(0, 16'h10, 16'h20, 0, 0, "under");
    op(0, 16'hFF, 16'hFF, 0, 0, "equal");
    op(0, 16'h80, 16'h01, 0, 1, "b2b1");
    op(0, 16'h00, 16'hFF, 0, 0, "b2b2");
    op(0, 16'h00, 16'h00, 1, 0, "bin");
    sel = 0; av = 16'h5A; bv = 16'h21; bi = 0; st = 1;
    @(negedge clk);
    st = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", 16'(busy8), 16'h0);
    chk("abort_done", 16'(done8), 16'h0);
    chk("abort_d", {8'b0, d8}, 16'h0);
    chk("abort_bout", {15'b0, bo8}, 16'h0);
    @(negedge clk);
    #2 rst_n = 1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_nodone", {14'b0, busy8, done8}, 16'h0);
    end
    op(0, 16'h09, 16'h03, 0, 0, "after_rst");
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom_range(0, 1));
      h = $urandom_range(0, 3) == 0;
      op(s, x, y, c, h, "rnd");
      if (h) op(s, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0, "rnd_b2b");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
